// File: rtl/gaussian_3x3_stage.sv
// ---------------------------------------------------------------------------
// gaussian_3x3_stage
//
// Streaming 3x3 Gaussian blur, kernel [1 2 1; 2 4 2; 1 2 1] / 16 with
// round-to-nearest. It sits between the down-sampler and the up-sampler.
// Interior pixels are filtered. Border pixels (first/last row, first/last
// column) pass through unchanged. Exactly WIDTH*HEIGHT pixels leave per
// frame, in raster order.
//
// Ports
//   clock      single clock, every register on its rising edge
//   reset      asynchronous, active-low
//   in_pixel   input pixel, raster order
//   in_valid   in_pixel is valid
//   in_ready   stage accepts in_pixel this cycle (0 while reset is low)
//   out_pixel  output pixel, held stable under back-pressure
//   out_valid  out_pixel is valid
//   out_ready  consumer accepts out_pixel
//   out_sof    (GAUSS_FRAME_MARK_EN only) marks output (0,0)
//   out_eof    (GAUSS_FRAME_MARK_EN only) marks output (HEIGHT-1,WIDTH-1)
//
// Optional feature macro: GAUSS_FRAME_MARK_EN adds out_sof/out_eof.
//
// Flow: FILL takes the first WIDTH+1 pixels. RUN turns every accepted input
// into one output, which lands in the output register the following cycle.
// FLUSH drains the last WIDTH+1 outputs from the line buffers with no
// further input.
// ---------------------------------------------------------------------------
module gaussian_3x3_stage #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_valid,
    input  logic              out_ready
`ifdef GAUSS_FRAME_MARK_EN
    ,
    output logic              out_sof,
    output logic              out_eof
`endif
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SUM_W = DATA_W + 4;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(HEIGHT - 2);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [COL_W-1:0]  in_col_reg, out_col_reg;
    logic [ROW_W-1:0]  in_row_reg, out_row_reg;
    logic [DATA_W-1:0] out_pixel_reg;
    logic              out_valid_reg;

    // lb_old holds the row two rows above the incoming one. lb_new holds the
    // row directly above. Both are read asynchronously at the input column.
    // That lets each accept shift a full column into the window within the
    // same cycle.
    logic [DATA_W-1:0] lb_old [WIDTH];
    logic [DATA_W-1:0] lb_new [WIDTH];

    // Window indexed [row][col]. Column 2 is the newest. Row 2 is the
    // incoming row.
    logic [DATA_W-1:0] win_reg  [3][3];
    logic [DATA_W-1:0] win_next [3][3];
    logic [DATA_W-1:0] col_vec  [3];

    logic              slot_free;
    logic              in_fire;
    logic              load_out;
    logic              interior;
    logic              out_at_last;
    logic              in_at_last;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_rnd;
    logic [DATA_W-1:0] filt_pixel;
    logic [DATA_W-1:0] flush_pixel;
    logic [DATA_W-1:0] load_pixel;

    // ---------------- handshake ----------------
    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = reset && (state_reg != ST_FLUSH) && slot_free;
    assign in_fire   = in_valid && in_ready;
    assign load_out  = ((state_reg == ST_RUN) && in_fire) ||
                       ((state_reg == ST_FLUSH) && slot_free);

    assign in_at_last  = (in_row_reg == ROW_LAST) && (in_col_reg == COL_LAST);
    assign out_at_last = (out_row_reg == ROW_LAST) && (out_col_reg == COL_LAST);

    // ---------------- window ----------------
    assign col_vec[0] = lb_old[in_col_reg];
    assign col_vec[1] = lb_new[in_col_reg];
    assign col_vec[2] = in_pixel;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        assign win_next[gi][0] = win_reg[gi][1];
        assign win_next[gi][1] = win_reg[gi][2];
        assign win_next[gi][2] = col_vec[gi];
    end

    // Weights are 1, 2 or 4. Each tap is shifted left once for every axis
    // on which it sits in the centre.
    always_comb begin
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + (SUM_W'(win_next[r][c]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
            end
        end
    end

    assign sum_rnd    = sum + SUM_W'(8);
    assign filt_pixel = sum_rnd[SUM_W-1:4];

    // The output being produced is always the window centre. On a row wrap
    // the window straddles two lines, but the centre is then a column-0 or
    // column-(WIDTH-1) pixel, so it passes through.
    assign interior = (out_row_reg != '0) && (out_row_reg != ROW_LAST) &&
                      (out_col_reg != '0) && (out_col_reg != COL_LAST);

    // Once the last input is in, lb_old holds row HEIGHT-2 and lb_new holds
    // row HEIGHT-1.
    assign flush_pixel = (out_row_reg == ROW_PENULT) ? lb_old[out_col_reg]
                                                     : lb_new[out_col_reg];

    always_comb begin
        load_pixel = flush_pixel;
        if (state_reg == ST_RUN) begin
            load_pixel = interior ? filt_pixel : win_next[1][1];
        end
    end

    // ---------------- state ----------------
    // FLUSH hands over to FILL as the final output is loaded. FILL only
    // accepts when the output register is empty or draining. So the next
    // frame can never start ahead of the final transfer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL:  if (in_fire && (in_row_reg == ROW_ONE) && (in_col_reg == '0))
                          state_next = ST_RUN;
            ST_RUN:   if (in_fire && in_at_last)
                          state_next = ST_FLUSH;
            ST_FLUSH: if (load_out && out_at_last)
                          state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_FILL;
            in_col_reg    <= '0;
            in_row_reg    <= '0;
            out_col_reg   <= '0;
            out_row_reg   <= '0;
            out_pixel_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (in_fire) begin
                if (in_col_reg == COL_LAST) begin
                    in_col_reg <= '0;
                    in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;
                end else begin
                    in_col_reg <= in_col_reg + 1'b1;
                end
            end
            if (load_out) begin
                out_pixel_reg <= load_pixel;
                out_valid_reg <= 1'b1;
                if (out_col_reg == COL_LAST) begin
                    out_col_reg <= '0;
                    out_row_reg <= (out_row_reg == ROW_LAST) ? '0 : out_row_reg + 1'b1;
                end else begin
                    out_col_reg <= out_col_reg + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Line buffers and window carry no reset. Stale contents only ever reach
    // taps whose result is discarded by border passthrough.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            lb_old[in_col_reg] <= lb_new[in_col_reg];
            lb_new[in_col_reg] <= in_pixel;
            win_reg            <= win_next;
        end
    end

    assign out_pixel = out_pixel_reg;
    assign out_valid = out_valid_reg;

`ifdef GAUSS_FRAME_MARK_EN
    logic out_sof_reg, out_eof_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_sof_reg <= 1'b0;
            out_eof_reg <= 1'b0;
        end else if (load_out) begin
            out_sof_reg <= (out_row_reg == '0) && (out_col_reg == '0);
            out_eof_reg <= out_at_last;
        end else if (out_ready) begin
            out_sof_reg <= 1'b0;
            out_eof_reg <= 1'b0;
        end
    end

    assign out_sof = out_sof_reg;
    assign out_eof = out_eof_reg;
`endif

endmodule

// File: tb/tb_gaussian_3x3_stage.sv
module tb_gaussian_3x3_stage;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready = 1'b1;
`ifdef GAUSS_FRAME_MARK_EN
    logic       out_sof, out_eof;
`endif

    always #5 clock = ~clock;

    gaussian_3x3_stage #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef GAUSS_FRAME_MARK_EN
        ,
        .out_sof   (out_sof),
        .out_eof   (out_eof)
`endif
    );

    typedef struct {
        int ir; int ic; int iv;   // impulse position and value
        int orow; int ocol;       // output to inspect
        int ev;                   // hand-computed expected value
    } vec_t;

    vec_t       vecs[$];
    int         total = 0;
    int         bad   = 0;

    logic [7:0] src[$];
    int         src_idx = 0;
    bit         drive_en = 1'b0;
    bit         gaps = 1'b0;
    logic [7:0] got[$];
    bit         got_sof[$];
    bit         got_eof[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'h00;
    int         stab_bad = 0;
    int         stall_seen = 0;
    bit         low_en = 1'b0;
    int         low_cnt = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(int ir, int ic, int iv, int orow, int ocol, int ev);
        vec_t v;
        v.ir = ir; v.ic = ic; v.iv = iv; v.orow = orow; v.ocol = ocol; v.ev = ev;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, then sample just after it. Sampled values
    // are those the DUT sees at the next rising edge.
    always @(negedge clock) begin
        in_valid  = drive_en && (src_idx < src.size()) && (!gaps || $urandom_range(1) == 1);
        in_pixel  = (src_idx < src.size()) ? src[src_idx] : 8'h00;
        out_ready = !gaps || ($urandom_range(1) == 1);
        #1;
        if (reset) begin
            if (low_en && got.size() < N && !in_ready) low_cnt++;
            if (prev_stall) begin
                stall_seen++;
                if (!out_valid || out_pixel !== prev_pix) stab_bad++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pixel;
            if (out_valid && out_ready) begin
                got.push_back(out_pixel);
`ifdef GAUSS_FRAME_MARK_EN
                got_sof.push_back(out_sof);
                got_eof.push_back(out_eof);
`endif
            end
            if (in_valid && in_ready) src_idx++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: a direct 2-D convolution of the source frame at 'base'.
    function automatic int ref_out(int base, int r, int c);
        int s;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return int'(src[base + r * W + c]);
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(src[base + (r + dr) * W + (c + dc)]) * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
        return (s + 8) >> 4;
    endfunction

    task automatic compare_frame(string tag, int base);
        int mism = 0;
        for (int i = 0; i < N; i++) begin
            int a = (base + i < got.size()) ? int'(got[base + i]) : -1;
            if (a != ref_out(base, i / W, i % W)) mism++;
        end
        chk(tag, mism, 0);
    endtask

    task automatic run_frame(int n_out);
        got.delete(); got_sof.delete(); got_eof.delete();
        src_idx  = 0;
        drive_en = 1'b1;
        for (int cyc = 0; cyc < 4000 && got.size() < n_out; cyc++) @(posedge clock);
        repeat (5) @(posedge clock);
        #1 drive_en = 1'b0;
        chk("output_count", got.size(), n_out);
    endtask

    initial begin
        int last_ir, last_ic, last_iv;

        add_vec(3, 3, 160, 3, 3, 40);
        add_vec(3, 3, 160, 2, 3, 20);
        add_vec(3, 3, 160, 4, 3, 20);
        add_vec(3, 3, 160, 3, 2, 20);
        add_vec(3, 3, 160, 3, 4, 20);
        add_vec(3, 3, 160, 2, 2, 10);
        add_vec(3, 3, 160, 2, 4, 10);
        add_vec(3, 3, 160, 4, 2, 10);
        add_vec(3, 3, 160, 4, 4, 10);
        add_vec(3, 3, 160, 1, 3, 0);
        add_vec(3, 3, 160, 3, 5, 0);
        add_vec(3, 3, 160, 0, 0, 0);
        add_vec(0, 4, 160, 0, 4, 160);
        add_vec(0, 4, 160, 1, 4, 20);
        add_vec(0, 4, 160, 1, 3, 10);
        add_vec(0, 4, 160, 1, 5, 10);
        add_vec(0, 4, 160, 0, 3, 0);
        add_vec(0, 4, 160, 2, 4, 0);
        add_vec(5, 7, 200, 5, 7, 200);
        add_vec(5, 7, 200, 4, 6, 13);
        add_vec(5, 7, 200, 4, 7, 0);
        add_vec(5, 7, 200, 5, 6, 0);
        add_vec(5, 0, 80, 5, 0, 80);
        add_vec(5, 0, 80, 4, 1, 5);
        add_vec(5, 0, 80, 4, 0, 0);
        add_vec(2, 5, 255, 2, 5, 64);
        add_vec(2, 5, 255, 1, 6, 16);
        add_vec(2, 5, 255, 3, 5, 32);
        add_vec(2, 5, 255, 1, 5, 32);

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        reset = 1'b1;
        #1 chk("ready_after_rst", int'(in_ready), 1);

        // constant frame, no gaps
        @(posedge clock); #1;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(8'd100);
        low_cnt = 0; low_en = 1'b1;
        run_frame(N);
        low_en = 1'b0;
        compare_frame("const_frame", 0);
        chk("const_first_px", int'(got[0]), 100);
        chk("flush_in_ready_low", low_cnt, W + 1);

        // impulse table
        last_ir = -1; last_ic = -1; last_iv = -1;
        for (int k = 0; k < vecs.size(); k++) begin
            int idx, act;
            if (vecs[k].ir != last_ir || vecs[k].ic != last_ic || vecs[k].iv != last_iv) begin
                last_ir = vecs[k].ir; last_ic = vecs[k].ic; last_iv = vecs[k].iv;
                @(posedge clock); #1;
                src.delete();
                for (int i = 0; i < N; i++)
                    src.push_back((i == last_ir * W + last_ic) ? 8'(last_iv) : 8'd0);
                run_frame(N);
                compare_frame($sformatf("impulse(%0d,%0d)_frame", last_ir, last_ic), 0);
            end
            idx = vecs[k].orow * W + vecs[k].ocol;
            act = (idx < got.size()) ? int'(got[idx]) : -1;
            chk($sformatf("imp(%0d,%0d)=%0d out(%0d,%0d)", vecs[k].ir, vecs[k].ic, vecs[k].iv,
                          vecs[k].orow, vecs[k].ocol), act, vecs[k].ev);
        end

        // random frame with random gaps on both sides
        @(posedge clock); #1;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(8'($urandom_range(255)));
        stab_bad = 0; stall_seen = 0; gaps = 1'b1;
        run_frame(N);
        gaps = 1'b0;
        compare_frame("random_gaps_frame", 0);
        chk("stall_data_stable", stab_bad, 0);
        chk("stalls_exercised", int'(stall_seen > 0), 1);

        // reset in the middle of a frame
        @(posedge clock); #1;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(8'($urandom_range(255)));
        got.delete(); src_idx = 0; drive_en = 1'b1;
        for (int cyc = 0; cyc < 500 && src_idx < 20; cyc++) @(posedge clock);
        #1;
        chk("reached_20_inputs", int'(src_idx >= 20), 1);
        drive_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(8'(i));
        run_frame(N);
        compare_frame("ramp_after_reset", 0);

        // two frames back to back
        @(posedge clock); #1;
        src.delete();
        for (int i = 0; i < 2 * N; i++) src.push_back(8'($urandom_range(255)));
        run_frame(2 * N);
        compare_frame("b2b_frame0", 0);
        compare_frame("b2b_frame1", N);
`ifdef GAUSS_FRAME_MARK_EN
        begin
            int sof_bad = 0, eof_bad = 0;
            for (int i = 0; i < got_sof.size(); i++) begin
                if (got_sof[i] != ((i % N) == 0)) sof_bad++;
                if (got_eof[i] != ((i % N) == N - 1)) eof_bad++;
            end
            chk("mark_count", got_sof.size(), 2 * N);
            chk("sof_positions", sof_bad, 0);
            chk("eof_positions", eof_bad, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
